// File: rtl/cfg_pkt_pkg.sv
// Shared config-packet definitions: field positions, type codes, cycle flags and MIDs.
// Reused by the initiator and by every per-module config responder.
package cfg_pkt_pkg;

  localparam int CFG_W   = 134;
  localparam int FLAG_HI = 133;
  localparam int FLAG_LO = 132;
  localparam int TYPE_HI = 127;
  localparam int TYPE_LO = 124;
  localparam int SEQ_HI  = 123;
  localparam int SEQ_LO  = 112;
  localparam int SRC_HI  = 111;
  localparam int SRC_LO  = 104;
  localparam int DST_HI  = 103;
  localparam int DST_LO  = 96;
  localparam int ADDR_HI = 95;
  localparam int ADDR_LO = 64;
  localparam int DATA_HI = 31;
  localparam int DATA_LO = 0;

  localparam logic [1:0] CFG_SOP = 2'b01;
  localparam logic [1:0] CFG_EOP = 2'b10;

  localparam logic [3:0] CFG_RD  = 4'b0001;
  localparam logic [3:0] CFG_WR  = 4'b0010;
  localparam logic [3:0] CFG_RSP = 4'b1011;

  localparam logic [7:0] MID_HOST = 8'd1;

  localparam logic [CFG_W-1:0] CFG_WORD2 = {CFG_EOP, 132'h0};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND1,
    ST_SEND2,
    ST_WAIT_RSP,
    ST_RSP2
  } cfg_init_state_t;

  function automatic logic [CFG_W-1:0] cfg_word1(
    input logic [3:0]  typ,
    input logic [11:0] seq,
    input logic [7:0]  src,
    input logic [7:0]  dst,
    input logic [31:0] addr,
    input logic [31:0] wdata
  );
    cfg_word1 = {CFG_SOP, 4'b0000, typ, seq, src, dst, addr, 32'h0, wdata};
  endfunction

endpackage

// File: rtl/cfg_rsp_match.sv
// Combinational match of a returning word-1 against the outstanding read,
// plus the saturating counter of discarded return first-words.
module cfg_rsp_match
  import cfg_pkt_pkg::*;
#(
  parameter logic [7:0] SELF_MID = MID_HOST
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CFG_W-1:0] cin_cfg_data,
  input  logic             cin_cfg_data_wr,
  input  logic             waiting,
  input  logic [11:0]      exp_seq,
  output logic             match,
  output logic [15:0]      drop_cnt
);

  logic        is_sop;
  logic [15:0] drop_cnt_reg;
  logic        unused_bits;

  assign is_sop = cin_cfg_data_wr && (cin_cfg_data[FLAG_HI:FLAG_LO] == CFG_SOP);

  assign match = waiting && is_sop
              && (cin_cfg_data[TYPE_HI:TYPE_LO] == CFG_RSP)
              && (cin_cfg_data[DST_HI:DST_LO]   == SELF_MID)
              && (cin_cfg_data[SEQ_HI:SEQ_LO]   == exp_seq);

  // Only first-words count; an orphaned word-2 is silently ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_reg <= 16'h0;
    end else if (is_sop && !match && (drop_cnt_reg != 16'hFFFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

  assign drop_cnt    = drop_cnt_reg;
  assign unused_bits = ^{cin_cfg_data[131:128], cin_cfg_data[SRC_HI:SRC_LO],
                         cin_cfg_data[ADDR_HI:DATA_LO]};

endmodule

// File: rtl/cfg_pkt_initiator.sv
// Host-side config packet master: request -> two-word packet on the chain head, read
// response matched by seq from the chain tail. Optional read timeout under CFG_TIMEOUT_EN.
module cfg_pkt_initiator
  import cfg_pkt_pkg::*;
#(
  parameter logic [7:0]  SELF_MID    = MID_HOST,
  parameter logic [15:0] TIMEOUT_CYC = 16'd4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [7:0]       req_dst_mid,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic [CFG_W-1:0] cout_cfg_data,
  output logic             cout_cfg_data_wr,
  input  logic             cin_cfg_ready,
  input  logic [CFG_W-1:0] cin_cfg_data,
  input  logic             cin_cfg_data_wr,
  output logic             cout_cfg_ready,
  output logic [15:0]      drop_cnt
);

  cfg_init_state_t  state_reg, state_next;
  logic             running_reg;
  logic             wr_reg;
  logic [11:0]      seq_reg;
  logic [11:0]      out_seq_reg;
  logic [CFG_W-1:0] word_reg;
  logic [31:0]      rdata_reg;
  logic             resp_valid_reg;

  logic             emit;
  logic             accept;
  logic             ready_c;
  logic             done_ok;
  logic             done_to;
  logic             match;
  logic             eop_in;
  logic             timeout_hit;

  assign eop_in = cin_cfg_data_wr && (cin_cfg_data[FLAG_HI:FLAG_LO] == CFG_EOP);

  cfg_rsp_match #(
    .SELF_MID (SELF_MID)
  ) u_match (
    .clk             (clk),
    .rst_n           (rst_n),
    .cin_cfg_data    (cin_cfg_data),
    .cin_cfg_data_wr (cin_cfg_data_wr),
    .waiting         (state_reg == ST_WAIT_RSP),
    .exp_seq         (out_seq_reg),
    .match           (match),
    .drop_cnt        (drop_cnt)
  );

  // Words leave only in a cycle the chain head is ready, so the strobe is combinational.
  always_comb begin
    state_next = state_reg;
    emit       = 1'b0;
    accept     = 1'b0;
    ready_c    = 1'b0;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        ready_c = running_reg;
        if (req_valid && running_reg) begin
          accept     = 1'b1;
          state_next = ST_SEND1;
        end
      end
      ST_SEND1: begin
        if (cin_cfg_ready) begin
          emit       = 1'b1;
          state_next = ST_SEND2;
        end
      end
      ST_SEND2: begin
        if (cin_cfg_ready) begin
          emit       = 1'b1;
          state_next = wr_reg ? ST_IDLE : ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        if (match) begin
          state_next = ST_RSP2;
        end else if (timeout_hit) begin
          done_to    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_RSP2: begin
        if (eop_in) begin
          done_ok    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      running_reg    <= 1'b0;
      wr_reg         <= 1'b0;
      seq_reg        <= 12'h0;
      out_seq_reg    <= 12'h0;
      word_reg       <= '0;
      rdata_reg      <= 32'h0;
      resp_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      running_reg    <= 1'b1;
      resp_valid_reg <= done_ok | done_to;
      if (accept) begin
        wr_reg      <= req_wr;
        out_seq_reg <= seq_reg;
        word_reg    <= cfg_word1(req_wr ? CFG_WR : CFG_RD, seq_reg, SELF_MID,
                                 req_dst_mid, req_addr, req_wr ? req_wdata : 32'h0);
      end else if (emit) begin
        word_reg <= (state_reg == ST_SEND1) ? CFG_WORD2 : '0;
      end
      if (emit && (state_reg == ST_SEND2)) begin
        seq_reg <= seq_reg + 12'd1;
      end
      if (match) begin
        rdata_reg <= cin_cfg_data[DATA_HI:DATA_LO];
      end else if (done_to) begin
        rdata_reg <= 32'hFFFF_FFFF;
      end
    end
  end

`ifdef CFG_TIMEOUT_EN
  logic [15:0] to_cnt_reg;
  logic        resp_err_reg;

  // Counter sits at zero outside WAIT_RSP, so it starts from 0 on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_reg   <= 16'h0;
      resp_err_reg <= 1'b0;
    end else begin
      to_cnt_reg   <= (state_reg == ST_WAIT_RSP) ? to_cnt_reg + 16'd1 : 16'h0;
      resp_err_reg <= done_to;
    end
  end

  assign timeout_hit = (state_reg == ST_WAIT_RSP) && (to_cnt_reg == TIMEOUT_CYC - 16'd1);
  assign resp_err    = resp_err_reg;
`else
  logic [15:0] unused_timeout_cyc;

  assign unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
  assign resp_err           = 1'b0;
`endif

  assign req_ready        = ready_c;
  assign resp_valid       = resp_valid_reg;
  assign resp_rdata       = rdata_reg;
  assign cout_cfg_data    = word_reg;
  assign cout_cfg_data_wr = emit;
  assign cout_cfg_ready   = 1'b1;

endmodule

// File: tb/tb_cfg_pkt_initiator.sv
// Directed bench for cfg_pkt_initiator with a queue-based packet/response model.
// Exercises the timeout path when built with CFG_TIMEOUT_EN.
module tb_cfg_pkt_initiator;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_wr;
  logic [7:0]   req_dst_mid;
  logic [31:0]  req_addr;
  logic [31:0]  req_wdata;
  logic         resp_valid;
  logic [31:0]  resp_rdata;
  logic         resp_err;
  logic [133:0] cout_cfg_data;
  logic         cout_cfg_data_wr;
  logic         cin_cfg_ready;
  logic [133:0] cin_cfg_data;
  logic         cin_cfg_data_wr;
  logic         cout_cfg_ready;
  logic [15:0]  drop_cnt;

  cfg_pkt_initiator #(
    .SELF_MID    (8'd1),
    .TIMEOUT_CYC (16'd16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_wr           (req_wr),
    .req_dst_mid      (req_dst_mid),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_err         (resp_err),
    .cout_cfg_data    (cout_cfg_data),
    .cout_cfg_data_wr (cout_cfg_data_wr),
    .cin_cfg_ready    (cin_cfg_ready),
    .cin_cfg_data     (cin_cfg_data),
    .cin_cfg_data_wr  (cin_cfg_data_wr),
    .cout_cfg_ready   (cout_cfg_ready),
    .drop_cnt         (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;
  bit quiet    = 1'b0;

  // Model state: expected chain words, expected responses, seq and drop bookkeeping.
  logic [133:0] exp_tx[$];
  logic [32:0]  exp_rsp[$];
  logic [11:0]  m_seq     = 12'h0;
  logic [11:0]  m_out_seq = 12'h0;
  bit           m_wait    = 1'b0;
  bit           m_rsp2    = 1'b0;
  logic [31:0]  m_rdata   = 32'h0;
  logic [15:0]  m_drop    = 16'h0;

  logic [133:0] last_w1    = '0;
  logic [31:0]  last_rdata = 32'h0;
  logic         last_err   = 1'b0;
  logic [133:0] W2;

  task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [133:0] rsp_w1(input logic [11:0] seq, input logic [7:0] dst,
                                          input logic [31:0] addr, input logic [31:0] data);
    return {2'b01, 4'b0000, 4'b1011, seq, 8'h07, dst, addr, 32'h0, data};
  endfunction

  // Per-cycle compare against the model.
  initial begin
    logic [133:0] w;
    logic [32:0]  r;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        if (cout_cfg_data_wr) begin
          chk("strobe_vs_ready", cin_cfg_ready, 1);
          if (exp_tx.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_unexpected actual=%0h required=no_word", cout_cfg_data);
          end else begin
            w = exp_tx.pop_front();
            chk("tx_word", cout_cfg_data, w);
            if (cout_cfg_data[133:132] == 2'b01) last_w1 = cout_cfg_data;
          end
        end
        if (exp_rsp.size() > 0) begin
          r = exp_rsp.pop_front();
          chk("resp_valid", resp_valid, 1);
          chk("resp_rdata", resp_rdata, r[31:0]);
          chk("resp_err", resp_err, r[32]);
          last_rdata = resp_rdata;
          last_err   = resp_err;
          $display("RSP rdata=%08h err=%0b", resp_rdata, resp_err);
        end else begin
          chk("resp_idle", resp_valid, 0);
        end
        chk("drop_cnt", drop_cnt, m_drop);
      end
    end
  end

  task automatic issue(input bit wr, input logic [7:0] dst, input logic [31:0] addr,
                       input logic [31:0] wdata, input int stall);
    logic [133:0] w1;
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", req_ready, 1);
    w1 = {2'b01, 4'b0000, wr ? 4'b0010 : 4'b0001, m_seq, 8'h01, dst, addr, 32'h0,
          wr ? wdata : 32'h0};
    exp_tx.push_back(w1);
    exp_tx.push_back(W2);
    if (!quiet) $display("TXN %s seq=%03h dst=%02h addr=%08h wdata=%08h",
                         wr ? "WR" : "RD", m_seq, dst, addr, wdata);
    req_valid = 1'b1; req_wr = wr; req_dst_mid = dst; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk); chk("word1_strobe", cout_cfg_data_wr, 1);
    if (stall > 0) begin
      @(posedge clk); #1 cin_cfg_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk); chk("bp_hold", cout_cfg_data_wr, 0);
      end
      @(posedge clk); #1 cin_cfg_ready = 1'b1;
    end
    @(negedge clk); chk("word2_strobe", cout_cfg_data_wr, 1);
    @(negedge clk); chk("post_send_strobe", cout_cfg_data_wr, 0);
    if (!wr) begin
      m_wait    = 1'b1;
      m_out_seq = m_seq;
    end
    m_seq = m_seq + 12'd1;
  endtask

  task automatic send_ret(input logic [133:0] w);
    cin_cfg_data    = w;
    cin_cfg_data_wr = 1'b1;
    @(posedge clk); #1;
    cin_cfg_data_wr = 1'b0;
    cin_cfg_data    = '0;
    if (w[133:132] == 2'b01) begin
      if (m_wait && w[127:124] == 4'b1011 && w[103:96] == 8'h01 && w[123:112] == m_out_seq) begin
        m_wait  = 1'b0;
        m_rsp2  = 1'b1;
        m_rdata = w[31:0];
      end else if (m_drop != 16'hFFFF) begin
        m_drop = m_drop + 16'd1;
      end
    end else if (w[133:132] == 2'b10 && m_rsp2) begin
      m_rsp2 = 1'b0;
      exp_rsp.push_back({1'b0, m_rdata});
    end
  endtask

  initial begin
    logic [11:0] s;
    int n;
    W2 = {2'b10, 132'h0};
    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_dst_mid = 8'h0;
    req_addr = 32'h0; req_wdata = 32'h0; cin_cfg_ready = 1'b1;
    cin_cfg_data = '0; cin_cfg_data_wr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_cout_ready", cout_cfg_ready, 1);
    chk("rst_cout_wr", cout_cfg_data_wr, 0);
    chk("rst_cout_data", cout_cfg_data, 0);
    chk("rst_outputs", {resp_valid, resp_rdata, resp_err, drop_cnt}, 0);
    rst_n = 1'b1;
    @(negedge clk); chk("rel_req_ready", req_ready, 1);
    cmp_en = 1'b1;

    // Write, then a back-pressured read answered with DEADBEEF.
    issue(1'b1, 8'd7, 32'h7000_0003, 32'h11, 0);
    chk("lit_write_w1", last_w1,
        {2'b01, 4'b0000, 4'b0010, 12'h000, 8'h01, 8'h07, 32'h7000_0003, 32'h0, 32'h11});
    issue(1'b0, 8'd7, 32'h7000_0008, 32'h0, 3);
    chk("lit_read_seq", last_w1[123:112], 12'h001);
    send_ret(rsp_w1(m_out_seq, 8'h01, 32'h7000_0008, 32'hDEAD_BEEF));
    send_ret(W2);
    repeat (2) @(negedge clk);
    chk("lit_rdata", last_rdata, 32'hDEAD_BEEF);

    // Wrong seq, wrong dst, then the right answer.
    issue(1'b0, 8'd7, 32'h7000_000C, 32'h0, 0);
    s = m_out_seq;
    send_ret(rsp_w1(s + 12'd1, 8'h01, 32'h7000_000C, 32'hBAD0_BAD0)); send_ret(W2);
    send_ret(rsp_w1(s, 8'h05, 32'h7000_000C, 32'hBAD1_BAD1)); send_ret(W2);
    send_ret(rsp_w1(s, 8'h01, 32'h7000_000C, 32'hCAFE_F00D)); send_ret(W2);
    repeat (2) @(negedge clk);
    chk("lit_mismatch_drop", drop_cnt, 16'd2);
    chk("lit_mismatch_rdata", last_rdata, 32'hCAFE_F00D);

    // Stale first-word while idle.
    send_ret(rsp_w1(12'h003, 8'h01, 32'h0, 32'h0)); send_ret(W2);
    repeat (2) @(negedge clk);
    chk("lit_stale_drop", drop_cnt, 16'd3);

    issue(1'b0, 8'd9, 32'h9000_0000, 32'h0, 0);
    s = m_out_seq;
`ifdef CFG_TIMEOUT_EN
    repeat (16) @(posedge clk);
    #1;
    exp_rsp.push_back({1'b1, 32'hFFFF_FFFF});
    m_wait = 1'b0;
    repeat (2) @(negedge clk);
    chk("lit_to_err", last_err, 1'b1);
    chk("lit_to_rdata", last_rdata, 32'hFFFF_FFFF);
    send_ret(rsp_w1(s, 8'h01, 32'h9000_0000, 32'h1234_5678)); send_ret(W2);
    repeat (2) @(negedge clk);
    chk("lit_late_drop", drop_cnt, 16'd4);
`else
    repeat (40) @(negedge clk);
    send_ret(rsp_w1(s, 8'h01, 32'h9000_0000, 32'h1234_5678)); send_ret(W2);
    repeat (2) @(negedge clk);
    chk("lit_slow_rdata", last_rdata, 32'h1234_5678);
`endif

    // Run seq up to the wrap point.
    quiet = 1'b1;
    n = 0;
    while (m_seq != 12'h0 && n < 4096) begin
      issue(1'b1, 8'd3, 32'h3000_0000 + n, n, 0);
      n++;
    end
    chk("lit_seq_fff", last_w1[123:112], 12'hFFF);
    quiet = 1'b0;
    issue(1'b1, 8'd3, 32'h3000_1000, 32'h55, 0);
    chk("lit_seq_wrap", last_w1[123:112], 12'h000);

    // Park a write in SEND2 (seq 1 not yet advanced) and reset under it.
    @(negedge clk);
    chk("park_req_ready", req_ready, 1);
    exp_tx.push_back({2'b01, 4'b0000, 4'b0010, m_seq, 8'h01, 8'h04, 32'h4000_0000, 32'h0, 32'h66});
    exp_tx.push_back(W2);
    $display("TXN WR seq=%03h dst=04 addr=40000000 wdata=00000066 (reset in SEND2)", m_seq);
    req_valid = 1'b1; req_wr = 1'b1; req_dst_mid = 8'h04; req_addr = 32'h4000_0000; req_wdata = 32'h66;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk); chk("park_word1", cout_cfg_data_wr, 1);
    @(posedge clk); #1 cin_cfg_ready = 1'b0;
    @(negedge clk); chk("park_hold", cout_cfg_data_wr, 0);
    cmp_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("mid_rst_wr", cout_cfg_data_wr, 0);
    chk("mid_rst_data", cout_cfg_data, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    exp_tx.delete(); exp_rsp.delete();
    m_seq = 12'h0; m_drop = 16'h0; m_wait = 1'b0; m_rsp2 = 1'b0;
    @(negedge clk);
    cin_cfg_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk); chk("post_rst_req_ready", req_ready, 1);
    cmp_en = 1'b1;
    issue(1'b1, 8'd2, 32'h2000_0000, 32'h77, 0);
    chk("lit_post_rst_seq", last_w1[123:112], 12'h000);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cfg_pkt_initiator.md
Name: cfg_pkt_initiator

Overview:
- Host-side master for the 134-bit two-cycle configuration packet chain.
- Converts a simple register request (read/write, target MID, address, data) into a config packet and drives it onto the chain head.
- Collects the read response returning from the chain tail, matches it by sequence tag, and returns read data or a timeout error to the requester.
- It is the initiator counterpart of every per-module config responder (statistics, latency RAM, etc.).

Parameters:
- SELF_MID, 8'd1, MID placed in the src field of every request; only responses with dst == SELF_MID are consumed.
- TIMEOUT_CYC, 16'd4096, cycles in WAIT_RSP before a read is aborted (used only with CFG_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_wr  in  1  1 = write, 0 = read
- req_dst_mid  in  8  target module MID
- req_addr  in  32  register address
- req_wdata  in  32  write data
- resp_valid  out  1  one-cycle pulse, completion of a read
- resp_rdata  out  32  read data
- resp_err  out  1  valid with resp_valid; 1 = timeout
- cout_cfg_data  out  134  packet word to chain head
- cout_cfg_data_wr  out  1  word strobe
- cin_cfg_ready  in  1  chain head can accept a word
- cin_cfg_data  in  134  word returning from chain tail
- cin_cfg_data_wr  in  1  return word strobe
- cout_cfg_ready  out  1  tied 1; the return path is never back-pressured
- drop_cnt  out  16  saturating count of return first-words discarded

Behaviour:
- Packet word 1 layout:
  - [133:132]=01, [131:128]=0000
  - [127:124]: 0001 read / 0010 write; 1011 on a response
  - [123:112]=seq, [111:104]=src MID, [103:96]=dst MID
  - [95:64]=addr, [63:32]=0, [31:0]=wdata (0 for reads)
- Packet word 2 layout: [133:132]=10, all other bits 0.
- Responder behaviour: swaps the src/dst fields and preserves seq.
- Reset values: all outputs 0 except cout_cfg_ready=1; seq=0; state IDLE.
- States: IDLE, SEND1, SEND2, WAIT_RSP, RSP2.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all request fields, then go to SEND1.
- SEND1 / SEND2:
  - A word is emitted (cout_cfg_data_wr=1 for exactly one cycle, data registered) only in a cycle where cin_cfg_ready=1.
  - While cin_cfg_ready=0, cout_cfg_data_wr=0 and the state holds.
  - SEND2 → WAIT_RSP for a read. SEND2 → IDLE for a write; no response is expected and no resp_valid is generated.
  - seq increments by 1 after each SEND2 and wraps 12'hFFF→0.
- WAIT_RSP:
  - A return word matches when [133:132]=01, [127:124]=1011, [103:96]=SELF_MID and [123:112]=outstanding seq.
  - On a match, capture [31:0] and go to RSP2.
  - Any other first-word increments drop_cnt (saturating at 16'hFFFF); its second word is ignored.
- RSP2:
  - Wait for the return word with [133:132]=10.
  - Then pulse resp_valid with resp_rdata set and resp_err=0, and go to IDLE.
- Overall read latency: 2 send cycles minimum, plus chain round trip, plus 1.
- Return words arriving while in IDLE/SEND* are unmatched (stale): first-words increment drop_cnt.
- Simultaneous return word and timeout expiry: the match wins.
- Reset mid-transaction: abort immediately. No partial word is re-emitted; the responder side discards orphan word-2s.

Optional Feature:
- Macro CFG_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to WAIT_RSP and increments each cycle.
  - At TIMEOUT_CYC-1 with no match: resp_valid=1, resp_err=1, resp_rdata=32'hFFFFFFFF, go to IDLE.
  - A late response for that seq is counted in drop_cnt.
- Undefined: no counter; WAIT_RSP waits indefinitely; resp_err is tied 0.

Decomposition:
- Shared package cfg_pkt_pkg holds:
  - field bit positions
  - type codes (CFG_RD=4'b0001, CFG_WR=4'b0010, CFG_RSP=4'b1011)
  - cycle flags (CFG_SOP=2'b01, CFG_EOP=2'b10)
  - the MID constants
- These constants are reused by the responders.
- One natural sub-module: cfg_rsp_match, a combinational match on return word-1 plus the registered drop counter.

Test Plan:
- Write: req_wr=1, dst=8'd7, addr=32'h70000003, wdata=32'h11, ready=1.
  - Expect word1 = {01,0000,0010,12'h000,8'h01,8'h07,32'h70000003,32'h0,32'h11}, then word2 = {10,132'h0} on consecutive cycles.
  - Expect no resp_valid.
  - Expect seq=1 afterwards.
- Read with back-pressure: ready low for 3 cycles between word1 and word2.
  - Expect word2 to appear only after ready returns, and cout_cfg_data_wr never high while ready=0.
- Read response: return {01,0000,1011,seq,8'h07,8'h01,addr,0,32'hDEADBEEF} followed by word2.
  - Expect one resp_valid pulse with resp_rdata=32'hDEADBEEF and resp_err=0, 1 cycle after word2.
- Mismatch: return response with a wrong seq, then one with dst=8'h05, then the correct one.
  - Expect drop_cnt=2 and correct data delivered.
- Timeout (CFG_TIMEOUT_EN, TIMEOUT_CYC=16): no response.
  - Expect resp_err=1 and resp_rdata=32'hFFFFFFFF 16 cycles after WAIT_RSP entry.
  - Expect a later late response to give drop_cnt+1.
- Seq wrap and reset: issue 4096 writes and check seq returns to 0; then assert rst_n in SEND2.
  - Expect outputs zero, req_ready=1 and seq=0 after release.
